// File: rtl/apb3_pkg.sv
// ---------------------------------------------------------------------------
// apb3_pkg
// Shared definitions for the AXI4-Lite to APB3 bridge:
//   RESP_OKAY / RESP_SLVERR : AXI response encodings returned on BRESP/RRESP
//   apb_state_t             : bridge FSM states (IDLE, SETUP, ACCESS, RESP)
// ---------------------------------------------------------------------------
package apb3_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/axil_to_apb3.sv
// ---------------------------------------------------------------------------
// axil_to_apb3
// AXI4-Lite slave to APB3 master bridge. Carries one transaction at a time,
// alternates between reads and writes when both are pending, and returns
// PRDATA/PSLVERR as RDATA/RRESP/BRESP.
//
// Optional build macro:
//   AXIL_APB3_TIMEOUT_EN - bound the ACCESS phase to TIMEOUT_CYCLES cycles;
//                          on expiry the transfer ends with SLVERR (read
//                          data 0). Without it ACCESS waits for PREADY forever.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_axil_aw* / s_axil_w*      AXI4-Lite write address / data (WSTRB ignored)
//   s_axil_b*                   AXI4-Lite write response
//   s_axil_ar* / s_axil_r*      AXI4-Lite read address / data
//   m_apb3_paddr/psel/penable/pwrite/pwdata   APB3 request (registered)
//   m_apb3_pready/pslverror/prdata            APB3 completion
// ---------------------------------------------------------------------------
module axil_to_apb3
    import apb3_pkg::*;
#(
    parameter int AXI_AW         = 32,
    parameter int APB_AW         = 20,
    parameter int APB_DW         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [AXI_AW-1:0]   s_axil_awaddr,
    input  logic                s_axil_awvalid,
    output logic                s_axil_awready,

    input  logic [APB_DW-1:0]   s_axil_wdata,
    input  logic [APB_DW/8-1:0] s_axil_wstrb,
    input  logic                s_axil_wvalid,
    output logic                s_axil_wready,

    output logic [1:0]          s_axil_bresp,
    output logic                s_axil_bvalid,
    input  logic                s_axil_bready,

    input  logic [AXI_AW-1:0]   s_axil_araddr,
    input  logic                s_axil_arvalid,
    output logic                s_axil_arready,

    output logic [APB_DW-1:0]   s_axil_rdata,
    output logic [1:0]          s_axil_rresp,
    output logic                s_axil_rvalid,
    input  logic                s_axil_rready,

    output logic [APB_AW-1:0]   m_apb3_paddr,
    output logic                m_apb3_psel,
    output logic                m_apb3_penable,
    output logic                m_apb3_pwrite,
    output logic [APB_DW-1:0]   m_apb3_pwdata,
    input  logic                m_apb3_pready,
    input  logic                m_apb3_pslverror,
    input  logic [APB_DW-1:0]   m_apb3_prdata
);

    apb_state_t state;

    // Remembers which kind won the last grant; starts as "write" so the first
    // read/write conflict after reset goes to the read.
    logic last_write;

    logic write_eligible;
    logic read_eligible;
    logic grant_write;
    logic grant_read;

    // APB3 has no byte strobes, and only the low APB_AW address bits reach
    // the APB side; the remaining inputs are intentionally left unused.
    logic unused_bits;
    assign unused_bits = ^{s_axil_wstrb, s_axil_awaddr, s_axil_araddr, 32'(TIMEOUT_CYCLES)};

    // Grant decision. A write needs both AW and W so it is never half
    // accepted; on a conflict the kind not granted last time wins.
    always_comb begin
        write_eligible = s_axil_awvalid && s_axil_wvalid;
        read_eligible  = s_axil_arvalid;
        grant_write    = (state == IDLE) && write_eligible && (!read_eligible || !last_write);
        grant_read     = (state == IDLE) && read_eligible && (!write_eligible || last_write);
    end

    // Ready is only ever raised in the grant cycle, which is always in IDLE.
    assign s_axil_awready = grant_write;
    assign s_axil_wready  = grant_write;
    assign s_axil_arready = grant_read;

`ifdef AXIL_APB3_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Counter value seen in the last permitted ACCESS cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] access_cnt;
`endif

    // Bridge FSM. All APB and response outputs are registered here.
    // m_apb3_pwrite doubles as the direction of the transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_write     <= 1'b1;
            m_apb3_paddr   <= '0;
            m_apb3_psel    <= 1'b0;
            m_apb3_penable <= 1'b0;
            m_apb3_pwrite  <= 1'b0;
            m_apb3_pwdata  <= '0;
            s_axil_bresp   <= RESP_OKAY;
            s_axil_bvalid  <= 1'b0;
            s_axil_rdata   <= '0;
            s_axil_rresp   <= RESP_OKAY;
            s_axil_rvalid  <= 1'b0;
`ifdef AXIL_APB3_TIMEOUT_EN
            access_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_write || grant_read) begin
                        last_write     <= grant_write;
                        m_apb3_pwrite  <= grant_write;
                        m_apb3_paddr   <= grant_write ? s_axil_awaddr[APB_AW-1:0]
                                                      : s_axil_araddr[APB_AW-1:0];
                        if (grant_write) begin
                            m_apb3_pwdata <= s_axil_wdata;
                        end
                        m_apb3_psel    <= 1'b1;
                        m_apb3_penable <= 1'b0;
                        state          <= SETUP;
                    end
                end

                SETUP: begin
                    m_apb3_penable <= 1'b1;
`ifdef AXIL_APB3_TIMEOUT_EN
                    access_cnt     <= '0;
`endif
                    state          <= ACCESS;
                end

                ACCESS: begin
                    // PREADY is checked first so a completion in the expiry
                    // cycle is still a normal completion.
                    if (m_apb3_pready) begin
                        m_apb3_psel    <= 1'b0;
                        m_apb3_penable <= 1'b0;
                        state          <= RESP;
                        if (m_apb3_pwrite) begin
                            s_axil_bresp  <= m_apb3_pslverror ? RESP_SLVERR : RESP_OKAY;
                            s_axil_bvalid <= 1'b1;
                        end else begin
                            s_axil_rresp  <= m_apb3_pslverror ? RESP_SLVERR : RESP_OKAY;
                            s_axil_rdata  <= m_apb3_prdata;
                            s_axil_rvalid <= 1'b1;
                        end
                    end
`ifdef AXIL_APB3_TIMEOUT_EN
                    else if (access_cnt == CNT_LAST) begin
                        m_apb3_psel    <= 1'b0;
                        m_apb3_penable <= 1'b0;
                        state          <= RESP;
                        if (m_apb3_pwrite) begin
                            s_axil_bresp  <= RESP_SLVERR;
                            s_axil_bvalid <= 1'b1;
                        end else begin
                            s_axil_rresp  <= RESP_SLVERR;
                            s_axil_rdata  <= '0;
                            s_axil_rvalid <= 1'b1;
                        end
                    end else begin
                        access_cnt <= access_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    if (m_apb3_pwrite ? s_axil_bready : s_axil_rready) begin
                        s_axil_bvalid <= 1'b0;
                        s_axil_rvalid <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_to_apb3.sv
// ---------------------------------------------------------------------------
// tb_axil_to_apb3
// Scoreboard bench for axil_to_apb3. Stimulus tasks push the expected APB
// transfer and AXI response into queues; an APB slave model and a response
// monitor pop and compare independently. A reference memory, keyed by the
// low APB_AW address bits, predicts read data. Directed sections cover
// reset values, arbitration, latency, partial writes, backpressure, the
// optional timeout (AXIL_APB3_TIMEOUT_EN) and reset during ACCESS.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axil_to_apb3;

    localparam int AXI_AW         = 32;
    localparam int APB_AW         = 20;
    localparam int APB_DW         = 32;
    localparam int TIMEOUT_CYCLES = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [AXI_AW-1:0] s_axil_awaddr = '0;
    logic              s_axil_awvalid = 1'b0;
    logic              s_axil_awready;
    logic [APB_DW-1:0] s_axil_wdata = '0;
    logic [3:0]        s_axil_wstrb = '0;
    logic              s_axil_wvalid = 1'b0;
    logic              s_axil_wready;
    logic [1:0]        s_axil_bresp;
    logic              s_axil_bvalid;
    logic              s_axil_bready = 1'b1;
    logic [AXI_AW-1:0] s_axil_araddr = '0;
    logic              s_axil_arvalid = 1'b0;
    logic              s_axil_arready;
    logic [APB_DW-1:0] s_axil_rdata;
    logic [1:0]        s_axil_rresp;
    logic              s_axil_rvalid;
    logic              s_axil_rready = 1'b1;
    logic [APB_AW-1:0] m_apb3_paddr;
    logic              m_apb3_psel;
    logic              m_apb3_penable;
    logic              m_apb3_pwrite;
    logic [APB_DW-1:0] m_apb3_pwdata;
    logic              m_apb3_pready;
    logic              m_apb3_pslverror;
    logic [APB_DW-1:0] m_apb3_prdata;

    always #5 clk = ~clk;

    axil_to_apb3 #(
        .AXI_AW(AXI_AW), .APB_AW(APB_AW), .APB_DW(APB_DW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb), .s_axil_wvalid(s_axil_wvalid),
        .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready),
        .m_apb3_paddr(m_apb3_paddr), .m_apb3_psel(m_apb3_psel), .m_apb3_penable(m_apb3_penable),
        .m_apb3_pwrite(m_apb3_pwrite), .m_apb3_pwdata(m_apb3_pwdata), .m_apb3_pready(m_apb3_pready),
        .m_apb3_pslverror(m_apb3_pslverror), .m_apb3_prdata(m_apb3_prdata)
    );

    typedef struct {
        int          addr;
        logic        write;
        logic [31:0] wdata;
        int          waits;
        logic        err;
    } apb_item_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_item_t;

    apb_item_t   apb_q[$];
    logic [1:0]  exp_b[$];
    rsp_item_t   exp_r[$];
    logic [31:0] ref_mem[int];
    logic [31:0] slave_mem[int];

    int errors = 0;
    int checks = 0;
    int access_cycles = 0;
    bit random_ready = 1'b0;

    // Comparison helper: every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: awaited event did not occur (got none, expected one) at %0t", name, $time);
    endtask

    // Reference model: APB_AW-bit address space, unwritten words hold a hash.
    function automatic int keyOf(input logic [31:0] addr);
        return int'(addr % 32'h0010_0000);
    endfunction

    function automatic logic [31:0] defVal(input int key);
        return 32'h5A00_0000 ^ (32'(key) * 32'h9E37_79B1);
    endfunction

    function automatic logic [31:0] refRead(input int key);
        if (ref_mem.exists(key)) return ref_mem[key];
        return defVal(key);
    endfunction

    task automatic pushWrite(input logic [31:0] addr, input logic [31:0] data, input int waits, input logic err);
        apb_item_t it;
        it.addr = keyOf(addr); it.write = 1'b1; it.wdata = data; it.waits = waits; it.err = err;
        apb_q.push_back(it);
        exp_b.push_back(err ? 2'b10 : 2'b00);
        if (!err) ref_mem[keyOf(addr)] = data;
    endtask

    task automatic pushRead(input logic [31:0] addr, input int waits, input logic err);
        apb_item_t it;
        rsp_item_t r;
        it.addr = keyOf(addr); it.write = 1'b0; it.wdata = '0; it.waits = waits; it.err = err;
        apb_q.push_back(it);
        r.data = refRead(keyOf(addr));
        r.resp = err ? 2'b10 : 2'b00;
        exp_r.push_back(r);
    endtask

    // APB slave model: takes wait states and error from the queued item.
    initial begin : apb_slave
        apb_item_t cur;
        int cnt;
        bit active;
        active = 1'b0;
        cnt = 0;
        m_apb3_pready = 1'b0;
        m_apb3_pslverror = 1'b0;
        m_apb3_prdata = '0;
        forever begin
            @(negedge clk);
            m_apb3_pready = 1'b0;
            m_apb3_pslverror = 1'b0;
            if (!rst_n || !m_apb3_psel) begin
                active = 1'b0;
            end else if (!m_apb3_penable) begin
                if (apb_q.size() == 0) begin
                    failNow("unexpected_apb_setup");
                    active = 1'b0;
                end else begin
                    cur = apb_q.pop_front();
                    active = 1'b1;
                    cnt = cur.waits;
                    access_cycles = 0;
                    checkOutput("setup_paddr", 32'(m_apb3_paddr), 32'(cur.addr));
                    checkOutput("setup_pwrite", 32'(m_apb3_pwrite), 32'(cur.write));
                    if (cur.write) checkOutput("setup_pwdata", m_apb3_pwdata, cur.wdata);
                end
            end else if (active) begin
                access_cycles++;
                if (cur.write) checkOutput("access_pwdata_held", m_apb3_pwdata, cur.wdata);
                if (cnt == 0) begin
                    m_apb3_pready = 1'b1;
                    m_apb3_pslverror = cur.err;
                    if (cur.write) begin
                        if (!cur.err) slave_mem[int'(m_apb3_paddr)] = m_apb3_pwdata;
                    end else begin
                        m_apb3_prdata = slave_mem.exists(int'(m_apb3_paddr)) ?
                                        slave_mem[int'(m_apb3_paddr)] : defVal(int'(m_apb3_paddr));
                    end
                    active = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // Response monitor: pops on each handshake, checks held responses stay stable.
    initial begin : rsp_monitor
        logic [1:0] eb;
        rsp_item_t er;
        logic [31:0] held_data;
        logic [1:0] held_resp;
        bit held;
        held = 1'b0;
        held_data = '0;
        held_resp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                if (s_axil_bvalid && s_axil_bready) begin
                    if (exp_b.size() == 0) failNow("unexpected_bvalid");
                    else begin
                        eb = exp_b.pop_front();
                        checkOutput("bresp", 32'(s_axil_bresp), 32'(eb));
                    end
                end
                if (s_axil_rvalid) begin
                    if (held) begin
                        checkOutput("rdata_stable", s_axil_rdata, held_data);
                        checkOutput("rresp_stable", 32'(s_axil_rresp), 32'(held_resp));
                    end
                    if (s_axil_rready) begin
                        held = 1'b0;
                        if (exp_r.size() == 0) failNow("unexpected_rvalid");
                        else begin
                            er = exp_r.pop_front();
                            checkOutput("rdata", s_axil_rdata, er.data);
                            checkOutput("rresp", 32'(s_axil_rresp), 32'(er.resp));
                        end
                    end else begin
                        held = 1'b1;
                        held_data = s_axil_rdata;
                        held_resp = s_axil_rresp;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (random_ready) begin
            s_axil_bready = 1'($urandom);
            s_axil_rready = 1'($urandom);
        end
    endtask

    task automatic driveWrite(input logic [31:0] addr, input logic [31:0] data);
        bit got;
        int n;
        s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = 4'($urandom);
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        got = 1'b0; n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            if (s_axil_awready) begin
                got = 1'b1;
                checkOutput("wready_with_awready", 32'(s_axil_wready), 32'd1);
            end else n++;
        end
        if (!got) failNow("aw_w_handshake");
        tick();
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    endtask

    task automatic driveRead(input logic [31:0] addr);
        bit got;
        int n;
        s_axil_araddr = addr; s_axil_arvalid = 1'b1;
        got = 1'b0; n = 0;
        while (!got && n < 200) begin
            @(negedge clk);
            if (s_axil_arready) got = 1'b1;
            else n++;
        end
        if (!got) failNow("ar_handshake");
        tick();
        s_axil_arvalid = 1'b0;
    endtask

    // Waits until every queued expectation has been consumed.
    task automatic drain();
        int n;
        n = 0;
        while ((apb_q.size() + exp_b.size() + exp_r.size()) != 0 && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) begin
            failNow("drain");
            apb_q.delete(); exp_b.delete(); exp_r.delete();
        end
        tick();
    endtask

    task automatic applyStimulus(input bit is_write, input logic [31:0] addr, input logic [31:0] data,
                                 input int waits, input logic err);
        if (is_write) begin
            pushWrite(addr, data, waits, err);
            driveWrite(addr, data);
        end else begin
            pushRead(addr, waits, err);
            driveRead(addr);
        end
        drain();
    endtask

    initial begin : main
        logic [31:0] exp_data;
        int n;
        bit seen;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_awready", 32'(s_axil_awready), 0);
        checkOutput("rst_wready", 32'(s_axil_wready), 0);
        checkOutput("rst_arready", 32'(s_axil_arready), 0);
        checkOutput("rst_bvalid", 32'(s_axil_bvalid), 0);
        checkOutput("rst_rvalid", 32'(s_axil_rvalid), 0);
        checkOutput("rst_psel", 32'(m_apb3_psel), 0);
        checkOutput("rst_penable", 32'(m_apb3_penable), 0);
        checkOutput("rst_pwrite", 32'(m_apb3_pwrite), 0);
        checkOutput("rst_paddr", 32'(m_apb3_paddr), 0);
        checkOutput("rst_pwdata", m_apb3_pwdata, 0);
        checkOutput("rst_rdata", s_axil_rdata, 0);
        checkOutput("rst_bresp", 32'(s_axil_bresp), 0);
        checkOutput("rst_rresp", 32'(s_axil_rresp), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Four back-to-back conflicts: read wins first, then strict alternation.
        $display("[TB] arbitration alternation");
        for (int i = 0; i < 4; i++) begin
            pushRead(32'h0000_0200 + 32'(i * 4), 0, 1'b0);
            pushWrite(32'h0000_0100 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 0, 1'b0);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    bit got;
                    s_axil_awaddr = 32'h0000_0100 + 32'(i * 4);
                    s_axil_wdata = 32'hC0DE_0000 + 32'(i);
                    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
                    got = 1'b0;
                    for (int k = 0; k < 100 && !got; k++) begin
                        @(negedge clk);
                        got = s_axil_awready;
                    end
                    if (!got) failNow("conflict_write_grant");
                    @(posedge clk); #1;
                end
                s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    bit got;
                    s_axil_araddr = 32'h0000_0200 + 32'(i * 4);
                    s_axil_arvalid = 1'b1;
                    got = 1'b0;
                    for (int k = 0; k < 100 && !got; k++) begin
                        @(negedge clk);
                        got = s_axil_arready;
                    end
                    if (!got) failNow("conflict_read_grant");
                    @(posedge clk); #1;
                end
                s_axil_arvalid = 1'b0;
            end
        join
        drain();

        // Zero-wait read latency
        $display("[TB] zero-wait read");
        slave_mem[32'h40010] = 32'hDEAD_BEEF;
        ref_mem[32'h40010] = 32'hDEAD_BEEF;
        pushRead(32'h0004_0010, 0, 1'b0);
        driveRead(32'h0004_0010);
        @(negedge clk);
        checkOutput("t1_psel", 32'(m_apb3_psel), 1);
        checkOutput("t1_penable", 32'(m_apb3_penable), 0);
        checkOutput("t1_paddr", 32'(m_apb3_paddr), 32'h0004_0010);
        @(negedge clk);
        checkOutput("t2_penable", 32'(m_apb3_penable), 1);
        @(negedge clk);
        checkOutput("t3_rvalid", 32'(s_axil_rvalid), 1);
        checkOutput("t3_rdata", s_axil_rdata, 32'hDEAD_BEEF);
        checkOutput("t3_psel", 32'(m_apb3_psel), 0);
        drain();

        // Write with 3 wait states and slave error
        $display("[TB] waited write with slave error");
        applyStimulus(1'b1, 32'h0000_0123, 32'h0000_A5A5, 3, 1'b1);
        checkOutput("wait3_access_cycles", 32'(access_cycles), 4);

        // AW without W must not be accepted
        $display("[TB] AW held without W");
        pushWrite(32'h0000_0300, 32'h1111_2222, 1, 1'b0);
        s_axil_awaddr = 32'h0000_0300; s_axil_wdata = 32'h1111_2222;
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("aw_only_awready", 32'(s_axil_awready), 0);
            checkOutput("aw_only_psel", 32'(m_apb3_psel), 0);
        end
        tick();
        driveWrite(32'h0000_0300, 32'h1111_2222);
        drain();

        // Read backpressure with a second read waiting
        $display("[TB] read backpressure");
        s_axil_rready = 1'b0;
        exp_data = refRead(keyOf(32'h0000_0400));
        pushRead(32'h0000_0400, 0, 1'b0);
        driveRead(32'h0000_0400);
        pushRead(32'h0000_0404, 1, 1'b0);
        s_axil_araddr = 32'h0000_0404; s_axil_arvalid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = s_axil_rvalid;
        end
        if (!seen) failNow("bp_rvalid");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_rvalid_held", 32'(s_axil_rvalid), 1);
            checkOutput("bp_rdata_held", s_axil_rdata, exp_data);
            checkOutput("bp_no_grant", 32'(s_axil_arready), 0);
            checkOutput("bp_no_psel", 32'(m_apb3_psel), 0);
        end
        tick();
        s_axil_rready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = s_axil_arready;
        end
        if (!seen) failNow("bp_second_grant");
        tick();
        s_axil_arvalid = 1'b0;
        drain();

        // Randomised traffic with random response backpressure
        $display("[TB] random traffic");
        random_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom),
                          ($urandom & 32'hFFF0_0000) | (32'($urandom_range(0, 7)) << 2),
                          $urandom, $urandom_range(0, 3), $urandom_range(0, 5) == 0);
        end
        random_ready = 1'b0;
        s_axil_bready = 1'b1;
        s_axil_rready = 1'b1;
        tick();

`ifdef AXIL_APB3_TIMEOUT_EN
        // Stuck PREADY: transfer is cut after TIMEOUT_CYCLES ACCESS cycles
        $display("[TB] access timeout");
        begin
            apb_item_t it;
            rsp_item_t r;
            it.addr = keyOf(32'h0000_0500); it.write = 1'b0; it.wdata = '0; it.waits = 100000; it.err = 1'b0;
            apb_q.push_back(it);
            r.data = 32'h0; r.resp = 2'b10;
            exp_r.push_back(r);
        end
        driveRead(32'h0000_0500);
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (m_apb3_psel && m_apb3_penable) n++;
            if (s_axil_rvalid) seen = 1'b1;
        end
        if (!seen) failNow("timeout_rvalid");
        checkOutput("timeout_access_cycles", 32'(n), 32'(TIMEOUT_CYCLES));
        drain();
`endif

        // Reset during ACCESS discards the transaction
        $display("[TB] reset during access");
        begin
            apb_item_t it;
            it.addr = keyOf(32'h0000_0600); it.write = 1'b0; it.wdata = '0; it.waits = 100000; it.err = 1'b0;
            apb_q.push_back(it);
        end
        driveRead(32'h0000_0600);
        n = 0;
        for (int k = 0; k < 20 && n < 3; k++) begin
            @(negedge clk);
            if (m_apb3_psel && m_apb3_penable) n++;
        end
        checkOutput("pre_reset_access_seen", 32'(n), 3);
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset_psel", 32'(m_apb3_psel), 0);
        checkOutput("mid_reset_penable", 32'(m_apb3_penable), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("mid_reset_rvalid", 32'(s_axil_rvalid), 0);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_reset_rvalid", 32'(s_axil_rvalid), 0);
        end
        tick();
        applyStimulus(1'b0, 32'h0004_0010, 32'h0, 0, 1'b0);

        checkOutput("leftover_expectations", 32'(apb_q.size() + exp_b.size() + exp_r.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
